// File: rtl/block_dispatcher.sv
// block_dispatcher: issuing end of the core start/done handshake.
// Latches a block count on kernel_start, hands block IDs 0..nb-1 to the
// lowest-index idle core (at most one per cycle), reclaims cores on
// core_done and reports kernel_done once every block has completed.
// kernel_config currently carries only the num_blocks field (DATA_W bits).

module block_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              kernel_start,
    input  logic [DATA_W-1:0]                 kernel_config,
    output logic                              kernel_done,
    output logic                              busy,
    output logic [NUM_CORES-1:0]              core_start,
    output logic [NUM_CORES-1:0][DATA_W-1:0]  core_block_id,
    input  logic [NUM_CORES-1:0]              core_done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Number of set bits in a core vector, sized as a block counter.
    function automatic logic [DATA_W-1:0] popcount(input logic [NUM_CORES-1:0] vec);
        logic [DATA_W-1:0] cnt;
        cnt = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            cnt = cnt + DATA_W'(vec[i]);
        end
        return cnt;
    endfunction

    state_t                              state_r;
    state_t                              state_nxt_s;
    logic [DATA_W-1:0]                   nb_r;
    logic [DATA_W-1:0]                   issued_cnt_r;
    logic [DATA_W-1:0]                   done_cnt_r;
    logic [NUM_CORES-1:0]                core_busy_r;

    logic [NUM_CORES-1:0]                idle_s;
    logic [NUM_CORES-1:0]                pick_oh_s;
    logic                                issue_en_s;
    logic [NUM_CORES-1:0]                issue_oh_s;
    logic [NUM_CORES-1:0]                done_hit_s;
    logic [DATA_W-1:0]                   issued_cnt_nxt_s;
    logic [DATA_W-1:0]                   done_cnt_nxt_s;
    logic                                start_acc_s;

    logic                                kernel_done_s;
    logic                                busy_s;
    logic                                kernel_done_r;
    logic                                busy_r;
    logic [NUM_CORES-1:0]                core_start_r;
    logic [NUM_CORES-1:0][DATA_W-1:0]    core_block_id_r;

    // Issue selection and completion accounting, using this cycle's busy mask
    // so a core freed in this cycle is never re-picked in the same cycle.
    always_comb begin
        idle_s     = ~core_busy_r;
        // Isolate the lowest set bit: lowest-index idle core as a one-hot.
        pick_oh_s  = idle_s & (~idle_s + NUM_CORES'(1'b1));
        issue_en_s = (state_r == ST_DISPATCH) && (issued_cnt_r < nb_r) &&
                     (idle_s != {NUM_CORES{1'b0}});
        if (issue_en_s) begin
            issue_oh_s = pick_oh_s;
        end else begin
            issue_oh_s = {NUM_CORES{1'b0}};
        end
        if ((state_r == ST_DISPATCH) || (state_r == ST_WAIT)) begin
            done_hit_s = core_done & core_busy_r;
        end else begin
            done_hit_s = {NUM_CORES{1'b0}};
        end
        issued_cnt_nxt_s = issued_cnt_r + DATA_W'(issue_en_s);
        done_cnt_nxt_s   = done_cnt_r + popcount(done_hit_s);
        start_acc_s      = kernel_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (kernel_start) begin
                    if (kernel_config == {DATA_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DISPATCH;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DISPATCH: begin
                if (issue_en_s && (issued_cnt_nxt_s == nb_r)) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_DISPATCH;
                end
            end
            ST_WAIT: begin
                if (done_cnt_nxt_s == nb_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Kernel bookkeeping: block count, issue/completion counters, busy mask.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nb_r         <= {DATA_W{1'b0}};
            issued_cnt_r <= {DATA_W{1'b0}};
            done_cnt_r   <= {DATA_W{1'b0}};
            core_busy_r  <= {NUM_CORES{1'b0}};
        end else if (start_acc_s) begin
            nb_r         <= kernel_config;
            issued_cnt_r <= {DATA_W{1'b0}};
            done_cnt_r   <= {DATA_W{1'b0}};
            core_busy_r  <= {NUM_CORES{1'b0}};
        end else begin
            issued_cnt_r <= issued_cnt_nxt_s;
            done_cnt_r   <= done_cnt_nxt_s;
            core_busy_r  <= (core_busy_r & ~done_hit_s) | issue_oh_s;
        end
    end

    // Output decode from the state being entered, so flags line up with state.
    always_comb begin
        kernel_done_s = 1'b0;
        busy_s        = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                kernel_done_s = 1'b0;
                busy_s        = 1'b0;
            end
            ST_DISPATCH, ST_WAIT: begin
                kernel_done_s = 1'b0;
                busy_s        = 1'b1;
            end
            ST_DONE: begin
                kernel_done_s = 1'b1;
                busy_s        = 1'b0;
            end
            default: begin
                kernel_done_s = 1'b0;
                busy_s        = 1'b0;
            end
        endcase
    end

    // Registered outputs; a core's block ID is held until its next issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            kernel_done_r   <= 1'b0;
            busy_r          <= 1'b0;
            core_start_r    <= {NUM_CORES{1'b0}};
            core_block_id_r <= {(NUM_CORES*DATA_W){1'b0}};
        end else begin
            kernel_done_r <= kernel_done_s;
            busy_r        <= busy_s;
            core_start_r  <= issue_oh_s;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (issue_oh_s[i]) begin
                    core_block_id_r[i] <= issued_cnt_r;
                end
            end
        end
    end

    assign kernel_done   = kernel_done_r;
    assign busy          = busy_r;
    assign core_start    = core_start_r;
    assign core_block_id = core_block_id_r;

    block_dispatcher_chk #(
        .NUM_CORES (NUM_CORES)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .core_done (core_done),
        .core_busy (core_busy_r),
        .issue_oh  (issue_oh_s)
    );

endmodule

// Protocol checks for block_dispatcher.
module block_dispatcher_chk #(
    parameter int NUM_CORES = 4
) (
    input logic                 clk,
    input logic                 reset,
    input logic [NUM_CORES-1:0] core_done,
    input logic [NUM_CORES-1:0] core_busy,
    input logic [NUM_CORES-1:0] issue_oh
);

    // A completion from a core that holds no block is ignored by the design but flagged here.
    a_done_on_idle_core: assert property (@(posedge clk) disable iff (!reset)
        ((core_done & ~core_busy) == {NUM_CORES{1'b0}}));

    // A block is never issued to a core that still holds one.
    a_issue_to_busy_core: assert property (@(posedge clk) disable iff (!reset)
        ((issue_oh & core_busy) == {NUM_CORES{1'b0}}));

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: directed scenarios plus a
// randomized run, all compared against a block-level reference model.
module tb_block_dispatcher;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int OW = 2 + NC + NC*DW;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       kernel_start;
    logic [DW-1:0]              kernel_config;
    logic                       kernel_done;
    logic                       busy;
    logic [NC-1:0]              core_start;
    logic [NC-1:0][DW-1:0]      core_block_id;
    logic [NC-1:0]              core_done;
    logic [OW-1:0]              dut_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 idle, 1 running, 2 done.
    int                     m_phase = 0;
    int                     m_nb    = 0;
    int                     m_next  = 0;
    int                     m_fin   = 0;
    logic [NC-1:0]          m_busy  = '0;
    logic [NC-1:0]          m_start = '0;
    logic [NC-1:0][DW-1:0]  m_ids   = '0;
    logic [OW-1:0]          m_out   = '0;

    always #5 clk = ~clk;

    assign dut_out = {kernel_done, busy, core_start, core_block_id};

    block_dispatcher #(.NUM_CORES(NC), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .kernel_start  (kernel_start),
        .kernel_config (kernel_config),
        .kernel_done   (kernel_done),
        .busy          (busy),
        .core_start    (core_start),
        .core_block_id (core_block_id),
        .core_done     (core_done)
    );

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [NC-1:0] freed;
        int pick;
        m_start = '0;
        if (!reset) begin
            m_phase = 0; m_nb = 0; m_next = 0; m_fin = 0;
            m_busy = '0; m_ids = '0;
        end else if (kernel_start && m_phase != 1) begin
            m_nb = int'(kernel_config); m_next = 0; m_fin = 0; m_busy = '0;
            m_phase = (m_nb == 0) ? 2 : 1;
        end else if (m_phase == 1) begin
            freed = core_done & m_busy;
            pick = -1;
            if (m_next < m_nb) begin
                for (int i = NC-1; i >= 0; i--) begin
                    if (!m_busy[i]) pick = i;
                end
            end
            if (pick >= 0) begin
                m_start[pick] = 1'b1;
                m_ids[pick]   = DW'(m_next);
                m_busy[pick]  = 1'b1;
                m_next++;
            end
            m_busy = m_busy & ~freed;
            m_fin  = m_fin + $countones(freed);
            if (m_fin == m_nb) m_phase = 2;
        end
        m_out = {(m_phase == 2), (m_phase == 1), m_start, m_ids};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; kernel_start = 1'b1; kernel_config = 8'd5; core_done = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (dut_out !== {OW{1'b0}}) $display("FAIL reset_hold: got %h expected 0", dut_out);
            else n_pass++;
        end
        reset = 1'b1; kernel_start = 1'b0;
        tick();
        n_checks++;
        if (dut_out !== {OW{1'b0}} || dut_out !== m_out)
            $display("FAIL reset_release: got %h expected %h", dut_out, m_out);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [NC-1:0] exp_cs;
        kernel_config = 8'd3; kernel_start = 1'b1;
        tick();
        kernel_start = 1'b0;
        n_checks++;
        if ({kernel_done, busy, core_start} !== {1'b0, 1'b1, 4'b0000})
            $display("FAIL basic_latency: got kd=%b busy=%b cs=%b expected kd=0 busy=1 cs=0000", kernel_done, busy, core_start);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_cs = 4'b0001 << k;
            n_checks++;
            if (core_start !== exp_cs || core_block_id[k] !== DW'(k))
                $display("FAIL basic_issue%0d: got cs=%b id=%0d expected cs=%b id=%0d", k, core_start, core_block_id[k], exp_cs, k);
            else n_pass++;
            n_checks++;
            if (dut_out !== m_out) $display("FAIL basic_model: got %h expected %h", dut_out, m_out);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (core_start !== 4'b0000 || busy !== 1'b1)
            $display("FAIL basic_wait: got cs=%b busy=%b expected cs=0000 busy=1", core_start, busy);
        else n_pass++;
        core_done = 4'b0001;
        tick();
        core_done = 4'b0000;
        n_checks++;
        if (kernel_done !== 1'b0 || dut_out !== m_out)
            $display("FAIL basic_partial: got %h expected %h", dut_out, m_out);
        else n_pass++;
        core_done = 4'b0110;
        tick();
        core_done = 4'b0000;
        n_checks++;
        if (kernel_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL basic_done: got kd=%b busy=%b expected kd=1 busy=0", kernel_done, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (kernel_done !== 1'b1 || dut_out !== m_out)
            $display("FAIL basic_done_hold: got %h expected %h", dut_out, m_out);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [NC-1:0] exp_cs;
        kernel_config = 8'd6; kernel_start = 1'b1;
        tick();
        kernel_start = 1'b0;
        n_checks++;
        if (kernel_done !== 1'b0 || busy !== 1'b1)
            $display("FAIL stall_restart: got kd=%b busy=%b expected kd=0 busy=1", kernel_done, busy);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_cs = 4'b0001 << k;
            n_checks++;
            if (core_start !== exp_cs || core_block_id[k] !== DW'(k))
                $display("FAIL stall_issue%0d: got cs=%b id=%0d expected cs=%b id=%0d", k, core_start, core_block_id[k], exp_cs, k);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (core_start !== 4'b0000 || busy !== 1'b1 || dut_out !== m_out)
            $display("FAIL stall_full: got %h expected %h", dut_out, m_out);
        else n_pass++;
        core_done = 4'b0100;
        tick();
        core_done = 4'b0000;
        n_checks++;
        if (core_start !== 4'b0000)
            $display("FAIL stall_same_cycle: got cs=%b expected 0000", core_start);
        else n_pass++;
        tick();
        n_checks++;
        if (core_start !== 4'b0100 || core_block_id[2] !== 8'd4)
            $display("FAIL stall_reissue2: got cs=%b id=%0d expected cs=0100 id=4", core_start, core_block_id[2]);
        else n_pass++;
        core_done = 4'b0001;
        tick();
        core_done = 4'b0000;
        tick();
        n_checks++;
        if (core_start !== 4'b0001 || core_block_id[0] !== 8'd5 ||
            core_block_id[1] !== 8'd1 || core_block_id[3] !== 8'd3)
            $display("FAIL stall_reissue0: got cs=%b ids=%h expected cs=0001 ids=03040105", core_start, core_block_id);
        else n_pass++;
        tick();
        n_checks++;
        if (dut_out !== m_out) $display("FAIL stall_model: got %h expected %h", dut_out, m_out);
        else n_pass++;
        core_done = 4'b1111;
        tick();
        core_done = 4'b0000;
        n_checks++;
        if (kernel_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL stall_done: got kd=%b busy=%b expected kd=1 busy=0", kernel_done, busy);
        else n_pass++;
    endtask

    task automatic test_zero_blocks();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (kernel_done !== 1'b0) $display("FAIL zero_idle: got kd=%b expected 0", kernel_done);
        else n_pass++;
        kernel_config = 8'd0; kernel_start = 1'b1;
        tick();
        kernel_start = 1'b0;
        n_checks++;
        if ({kernel_done, busy, core_start} !== {1'b1, 1'b0, 4'b0000})
            $display("FAIL zero_done: got kd=%b busy=%b cs=%b expected kd=1 busy=0 cs=0000", kernel_done, busy, core_start);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (core_start !== 4'b0000 || dut_out !== m_out)
                $display("FAIL zero_quiet: got %h expected %h", dut_out, m_out);
            else n_pass++;
        end
    endtask

    task automatic test_simul_done();
        kernel_config = 8'd4; kernel_start = 1'b1;
        tick();
        kernel_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (dut_out !== m_out) $display("FAIL simul_issue: got %h expected %h", dut_out, m_out);
            else n_pass++;
        end
        n_checks++;
        if (core_start !== 4'b1000 || core_block_id[3] !== 8'd3)
            $display("FAIL simul_last: got cs=%b id=%0d expected cs=1000 id=3", core_start, core_block_id[3]);
        else n_pass++;
        kernel_config = 8'd7; kernel_start = 1'b1;
        tick();
        kernel_start = 1'b0;
        n_checks++;
        if ({kernel_done, busy, core_start} !== {1'b0, 1'b1, 4'b0000})
            $display("FAIL simul_ignore_start: got kd=%b busy=%b cs=%b expected kd=0 busy=1 cs=0000", kernel_done, busy, core_start);
        else n_pass++;
        core_done = 4'b1111;
        tick();
        core_done = 4'b0000;
        n_checks++;
        if (kernel_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL simul_done: got kd=%b busy=%b expected kd=1 busy=0", kernel_done, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (core_start !== 4'b0000 || kernel_done !== 1'b1 || dut_out !== m_out)
            $display("FAIL simul_after: got %h expected %h", dut_out, m_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        kernel_config = 8'd10; kernel_start = 1'b1;
        tick();
        kernel_start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (core_start !== 4'b0010 || core_block_id[1] !== 8'd1)
            $display("FAIL mid_pre: got cs=%b id=%0d expected cs=0010 id=1", core_start, core_block_id[1]);
        else n_pass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (dut_out !== {OW{1'b0}}) $display("FAIL mid_reset: got %h expected 0", dut_out);
        else n_pass++;
        kernel_config = 8'd2; kernel_start = 1'b1;
        tick();
        kernel_start = 1'b0;
        tick();
        n_checks++;
        if (core_start !== 4'b0001 || core_block_id[0] !== 8'd0)
            $display("FAIL mid_new0: got cs=%b id=%0d expected cs=0001 id=0", core_start, core_block_id[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (core_start !== 4'b0010 || core_block_id[1] !== 8'd1)
            $display("FAIL mid_new1: got cs=%b id=%0d expected cs=0010 id=1", core_start, core_block_id[1]);
        else n_pass++;
        tick();
        core_done = 4'b0011;
        tick();
        core_done = 4'b0000;
        n_checks++;
        if (kernel_done !== 1'b1 || dut_out !== m_out)
            $display("FAIL mid_done: got %h expected %h", dut_out, m_out);
        else n_pass++;
    endtask

    task automatic test_random();
        int nb;
        int cyc;
        for (int kk = 0; kk < 5; kk++) begin
            nb = (kk == 0) ? 255 : int'($urandom_range(1, 24));
            kernel_config = DW'(nb); kernel_start = 1'b1;
            tick();
            kernel_start = 1'b0;
            n_checks++;
            if (dut_out !== m_out) $display("FAIL rand_start: got %h expected %h", dut_out, m_out);
            else n_pass++;
            cyc = 0;
            while (m_phase == 1 && cyc < 3000) begin
                core_done = NC'($urandom) & m_busy;
                if ($urandom_range(0, 7) == 0) begin
                    kernel_start = 1'b1; kernel_config = DW'($urandom);
                end else begin
                    kernel_start = 1'b0;
                end
                tick();
                core_done = '0; kernel_start = 1'b0;
                n_checks++;
                if (dut_out !== m_out) $display("FAIL rand_cycle nb=%0d: got %h expected %h", nb, dut_out, m_out);
                else n_pass++;
                cyc++;
            end
            n_checks++;
            if (kernel_done !== 1'b1) $display("FAIL rand_kernel_done nb=%0d: got kd=%b expected 1 within budget", nb, kernel_done);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; kernel_start = 1'b0; kernel_config = '0; core_done = '0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_blocks();
        test_simul_done();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
